// File: rtl/uart_packet_arbiter.sv
// ---------------------------------------------------------------------------
// UartPacketArbiter : round-robin, packet-granular arbiter feeding one UART
// transmitter from NUM_REQ byte-stream requesters.
//
// A requester is granted at packet granularity: once granted it owns the
// transmitter from its first byte through the byte flagged req_last_i. Each
// byte is accepted, sent with a one-cycle tx_start_o pulse, then the arbiter
// waits for the transmitter to go busy and return idle. If busy never shows
// up within BUSY_TIMEOUT cycles the packet is abandoned and the sticky
// timeout_err_o flag is raised.
//
// Optional feature (macro ARB_HEADER_EN): when defined, every packet is
// preceded by a header byte 0xA0 | granted_index.
//
// Parameters
//   NUM_REQ       number of requesters (2..8)
//   BUSY_TIMEOUT  cycles to wait for tx_busy_i after a start (1..65535)
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   req_valid_i    per-requester byte valid
//   req_data_i     per-requester byte, requester i at [8i+7:8i]
//   req_last_i     per-requester end-of-packet flag
//   req_ready_o    per-requester byte accept strobe (combinational)
//   tx_start_o     one-cycle start pulse to the transmitter
//   tx_data_o      byte to the transmitter, held until the next acceptance
//   tx_busy_i      transmitter busy
//   tx_ready_i     transmitter idle and able to accept
//   grant_o        one-hot current owner, zero when idle
//   timeout_err_o  sticky busy-timeout flag
// ---------------------------------------------------------------------------
module uart_packet_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   tx_start_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_busy_i,
    input  logic                   tx_ready_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   timeout_err_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               last_q, last_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    logic               sel_valid;
    logic [7:0]         sel_data;
    logic               sel_last;
    logic               accept;
    logic               busy_expired;
    logic [IW-1:0]      next_ptr;

    // Round-robin search: first valid requester at or after rr_ptr_q, wrapping.
    always_comb begin
        logic [IW-1:0] idx;
        idx        = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!pick_found && req_valid_i[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 8'h00;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == IW'(i)) begin
                sel_valid = req_valid_i[i];
                sel_data  = req_data_i[8*i +: 8];
                sel_last  = req_last_i[i];
            end
        end
    end

    assign accept       = (state_q == SEND) && tx_ready_i && sel_valid;
    assign busy_expired = (cnt_q + 16'd1) == 16'(BUSY_TIMEOUT);
    assign next_ptr     = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
`ifdef ARB_HEADER_EN
                    state_d = HDR;
`else
                    state_d = SEND;
`endif
                end
            end
            HDR: begin
`ifdef ARB_HEADER_EN
                if (tx_ready_i) state_d = WAIT_BUSY;
`else
                state_d = IDLE;
`endif
            end
            SEND: begin
                if (accept) state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_i)         state_d = WAIT_DONE;
                else if (busy_expired) state_d = IDLE;
            end
            WAIT_DONE: begin
                // A header is captured with last=0, so it always returns to SEND.
                if (tx_ready_i && !tx_busy_i) state_d = last_q ? IDLE : SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: the accept strobe goes only to the owner, in the accept cycle.
    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o = grant_q;
    end

    // Datapath next-state: grant, pointer, captured byte, timeout counter.
    always_comb begin
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    gidx_d  = pick_idx;
                end
            end
            HDR: begin
`ifdef ARB_HEADER_EN
                if (tx_ready_i) begin
                    tx_data_d  = 8'hA0 | 8'(gidx_q);
                    last_d     = 1'b0;
                    tx_start_d = 1'b1;
                    cnt_d      = '0;
                end
`endif
            end
            SEND: begin
                if (accept) begin
                    tx_data_d  = sel_data;
                    last_d     = sel_last;
                    tx_start_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            WAIT_BUSY: begin
                if (!tx_busy_i) begin
                    cnt_d = cnt_q + 16'd1;
                    if (busy_expired) begin
                        timeout_d = 1'b1;
                        grant_d   = '0;
                        rr_ptr_d  = next_ptr;
                    end
                end
            end
            WAIT_DONE: begin
                if (tx_ready_i && !tx_busy_i && last_q) begin
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant_o       = grant_q;
    assign tx_start_o    = tx_start_q;
    assign tx_data_o     = tx_data_q;
    assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_uart_packet_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for uart_packet_arbiter (NUM_REQ=4, BUSY_TIMEOUT=8).
// Requesters are byte queues; a transmitter model goes busy one cycle after
// each start. A packet-level round-robin model predicts the sequence of
// (byte, owner) pairs that must appear on tx_start_o.
// Honours ARB_HEADER_EN (expects a 0xA0|g header before each packet).
// ---------------------------------------------------------------------------
module tb_uart_packet_arbiter;

    localparam int N = 4;
`ifdef ARB_HEADER_EN
    localparam int HDRN = 1;
`else
    localparam int HDRN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic          tx_ready;
    logic [N-1:0]  grant;
    logic          timeout_err;

    uart_packet_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready),
        .tx_start_o(tx_start), .tx_data_o(tx_data),
        .tx_busy_i(tx_busy), .tx_ready_i(tx_ready),
        .grant_o(grant), .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Requester byte stores: driver pops dHead, main appends at dTail.
    logic [7:0] dData [N][256];
    logic       dLast [N][256];
    int         dHead [N] = '{0, 0, 0, 0};
    int         dTail [N] = '{0, 0, 0, 0};
    logic [N-1:0] hold = '0;
    logic [N-1:0] pendingAccept = '0;

    // Reference model packet store and round-robin pointer.
    logic [7:0] mData [N][256];
    logic       mLast [N][256];
    int         mHead [N] = '{0, 0, 0, 0};
    int         mTail [N] = '{0, 0, 0, 0};
    int         mPtr = 0;
    logic [7:0]   expData[$];
    logic [N-1:0] expGrant[$];

    int busyLen = 10;
    bit noBusy = 0;
    int busyCnt = 0;
    bit sbEnable = 1;
    int startCount = 0;
    bit prevStart = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    // Transmitter model: busy for busyLen cycles starting the cycle after a start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busyCnt <= 0;
        else if (tx_start && !noBusy) busyCnt <= busyLen;
        else if (busyCnt > 0) busyCnt <= busyCnt - 1;
    end
    assign tx_busy  = (busyCnt > 0);
    assign tx_ready = !tx_busy;

    // Requester driver: pop what was accepted at the last posedge, drive the next byte.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) if (pendingAccept[i]) dHead[i]++;
        for (int i = 0; i < N; i++) begin
            if (dHead[i] < dTail[i] && !hold[i]) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = dData[i][dHead[i]];
                req_last[i]         = dLast[i][dHead[i]];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
        #1;
        pendingAccept = req_ready;
        if (sbEnable && pendingAccept != '0)
            checkOutput("readyOwner", pendingAccept, (expGrant.size() > 0) ? expGrant[0] : '0);
    end

    // Start monitor / scoreboard.
    always @(negedge clk) begin
        if (tx_start) begin
            startCount++;
            checkOutput("startWidth", prevStart, 0);
            if (sbEnable) begin
                if (expData.size() == 0) begin
                    checkOutput("spuriousStart", 1, 0);
                end else begin
                    checkOutput("txData", tx_data, expData[0]);
                    checkOutput("txGrant", grant, expGrant[0]);
                    void'(expData.pop_front());
                    void'(expGrant.pop_front());
                end
            end
        end
        prevStart = tx_start;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int r, input int len, input logic [31:0] bytes);
        for (int k = 0; k < len; k++) begin
            dData[r][dTail[r]] = bytes[8*k +: 8];
            dLast[r][dTail[r]] = (k == len - 1);
            dTail[r]++;
            mData[r][mTail[r]] = bytes[8*k +: 8];
            mLast[r][mTail[r]] = (k == len - 1);
            mTail[r]++;
        end
    endtask

    function automatic int pickFirst(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) if (mask[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Packet-level round robin over everything loaded so far.
    task automatic predict();
        logic [N-1:0] mask;
        int g;
        bit endPkt;
        forever begin
            mask = '0;
            for (int r = 0; r < N; r++) mask[r] = (mHead[r] < mTail[r]);
            if (mask == '0) break;
            g = pickFirst(mask, mPtr);
            if (HDRN == 1) begin
                expData.push_back(8'hA0 | g[7:0]);
                expGrant.push_back(N'(1) << g);
            end
            endPkt = 0;
            while (!endPkt && mHead[g] < mTail[g]) begin
                expData.push_back(mData[g][mHead[g]]);
                expGrant.push_back(N'(1) << g);
                endPkt = mLast[g][mHead[g]];
                mHead[g]++;
            end
            mPtr = (g + 1) % N;
        end
    endtask

    task automatic clearQueues();
        #2;
        for (int r = 0; r < N; r++) begin
            dTail[r] = dHead[r];
            mHead[r] = mTail[r];
        end
    endtask

    function automatic bit drained();
        for (int r = 0; r < N; r++) if (dHead[r] < dTail[r]) return 0;
        return 1;
    endfunction

    task automatic runTraffic(input int budget);
        bit done = 0;
        for (int k = 0; k < budget; k++) begin
            if (expData.size() == 0 && drained() && grant == '0) begin
                done = 1;
                break;
            end
            tick();
        end
        checkOutput("drained", done, 1);
        checkOutput("expEmpty", expData.size(), 0);
    endtask

    task automatic waitStarts(input int target, input int budget);
        int k = 0;
        while (startCount < target && k < budget) begin
            tick();
            k++;
        end
        checkOutput("startSeen", startCount >= target, 1);
    endtask

    initial begin
        int base, first, other, k, starts, ready0;
        rst_n = 1'b0;
        repeat (3) tick();
        $display("[TB] reset values");
        checkOutput("rstGrant", grant, 0);
        checkOutput("rstStart", tx_start, 0);
        checkOutput("rstData", tx_data, 0);
        checkOutput("rstReady", req_ready, 0);
        checkOutput("rstTimeout", timeout_err, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] round robin req1/req3");
        applyStimulus(1, 1, 32'h55);
        applyStimulus(3, 1, 32'h77);
        predict();
        runTraffic(400);
        applyStimulus(1, 1, 32'h56);
        applyStimulus(3, 1, 32'h78);
        predict();
        runTraffic(400);

        $display("[TB] three byte packet from req0");
        base = startCount;
        applyStimulus(0, 3, 32'h00332211);
        predict();
        runTraffic(1000);
        checkOutput("pkt3Starts", startCount - base, 3 + HDRN);
        checkOutput("pkt3Grant", grant, 0);

        $display("[TB] req2 stalls mid packet");
        base = startCount;
        applyStimulus(2, 4, 32'h44434241);
        predict();
        waitStarts(base + HDRN + 1, 300);
        hold = 4'b0100;
        applyStimulus(0, 1, 32'h99);
        predict();
        starts = startCount;
        ready0 = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (req_ready[0]) ready0++;
        end
        checkOutput("holdStarts", startCount - starts, 0);
        checkOutput("holdReady0", ready0, 0);
        checkOutput("holdGrant", grant, 4'b0100);
        hold = '0;
        runTraffic(1500);

        $display("[TB] random traffic");
        for (int round = 0; round < 3; round++) begin
            busyLen = $urandom_range(1, 6);
            for (int r = 0; r < N; r++) begin
                int np;
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) applyStimulus(r, $urandom_range(1, 3), $urandom());
            end
            predict();
            runTraffic(3000);
        end

        $display("[TB] busy timeout");
        busyLen = 10;
        noBusy = 1;
        sbEnable = 0;
        first = pickFirst(4'b0110, mPtr);
        other = (first == 1) ? 2 : 1;
        base = startCount;
        applyStimulus(1, 1, 32'hA5);
        applyStimulus(2, 1, 32'h5A);
        waitStarts(base + 1, 100);
        checkOutput("toFirstGrant", grant, N'(1) << first);
        k = 0;
        while (!timeout_err && k < 40) begin
            tick();
            k++;
        end
        checkOutput("toCycles", k, 8);
        checkOutput("toGrantRel", grant, 0);
        waitStarts(base + 2, 100);
        checkOutput("toNextGrant", grant, N'(1) << other);
        clearQueues();
        k = 0;
        while (grant != '0 && k < 60) begin
            tick();
            k++;
        end
        checkOutput("toIdle", grant, 0);
        noBusy = 0;
        mPtr = (other + 1) % N;
        checkOutput("toSticky", timeout_err, 1);
        sbEnable = 1;
        runTraffic(200);

        $display("[TB] reset during second byte");
        base = startCount;
        applyStimulus(0, 4, 32'h0D0C0B0A);
        predict();
        waitStarts(base + HDRN + 2, 500);
        k = 0;
        while (!tx_busy && k < 20) begin
            tick();
            k++;
        end
        checkOutput("busySeen", tx_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arstGrant", grant, 0);
        checkOutput("arstStart", tx_start, 0);
        checkOutput("arstData", tx_data, 0);
        checkOutput("arstReady", req_ready, 0);
        checkOutput("arstTimeout", timeout_err, 0);
        clearQueues();
        expData.delete();
        expGrant.delete();
        mPtr = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        base = startCount;
        repeat (5) tick();
        checkOutput("noStaleStart", startCount - base, 0);
        checkOutput("postRstGrant", grant, 0);
        applyStimulus(3, 2, 32'h0000EEDD);
        predict();
        runTraffic(500);
        checkOutput("postRstStarts", startCount - base, 2 + HDRN);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
